// File: rtl/apb_master_bridge_pkg.sv
// rtl/apb_master_bridge_pkg.sv - shared FSM encodings and UART register offsets for the APB bridge
// Contents:
//   apb_state_t     bridge FSM state (IDLE/SETUP/ACCESS)
//   REG_UART_*      register offsets of the downstream UART APB slave
package apb_master_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_t;

    localparam logic [3:0] REG_UART_DATA = 4'h0;
    localparam logic [3:0] REG_UART_CTRL = 4'h4;
    localparam logic [3:0] REG_UART_STAT = 4'h8;
    localparam logic [3:0] REG_UART_INT  = 4'hC;

endpackage

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-beat command to APB transfer initiator with wait/timeout handling
// Ports:
//   PCLK, PRESETn                 clock, synchronous active-low reset
//   cmd_valid/ready/write/addr/wdata   requester command handshake
//   rsp_valid/rdata/err/timeout   one-cycle completion pulse plus held status
//   busy                          bridge not idle
//   PADDR/PSELx/PENABLE/PWRITE/PWDATA  APB request outputs
//   PREADY/PRDATA/PSLVERR         APB slave response inputs
module apb_master_bridge
    import apb_master_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PSELx,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  PREADY,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PSLVERR
);

    // Counter value seen on the last ACCESS cycle allowed before abort.
    localparam logic [15:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? 16'd0 : 16'(TIMEOUT_CYCLES - 1);

    apb_state_t  state;
    apb_state_t  state_next;
    logic [15:0] wait_cnt;
    logic        timeout_hit;

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == TO_LAST);

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (cmd_valid) state_next = ST_SETUP;
            ST_SETUP:  state_next = ST_ACCESS;
            ST_ACCESS: if (PREADY || timeout_hit) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == ST_IDLE);
        busy      = (state != ST_IDLE);
    end

    // Bus and response registers. PADDR/PWRITE/PWDATA only change on
    // acceptance, so they stay quiet between transfers.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            PADDR       <= '0;
            PWRITE      <= 1'b0;
            PWDATA      <= '0;
            PSELx       <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            wait_cnt    <= 16'd0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        PADDR   <= cmd_addr;
                        PWRITE  <= cmd_write;
                        PWDATA  <= cmd_write ? cmd_wdata : '0;
                        PSELx   <= 1'b1;
                        PENABLE <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    PENABLE  <= 1'b1;
                    wait_cnt <= 16'd0;
                end
                ST_ACCESS: begin
                    // PREADY is checked first so a completion on the timeout
                    // cycle is reported as a normal transfer.
                    if (PREADY) begin
                        PSELx       <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= PSLVERR;
                        rsp_rdata   <= PWRITE ? '0 : PRDATA;
                        rsp_timeout <= 1'b0;
                    end else if (timeout_hit) begin
                        PSELx       <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - scoreboard bench for apb_master_bridge with a stub APB slave
module tb_apb_master_bridge;
    import apb_master_bridge_pkg::*;

    logic       clk = 1'b0;
    logic       PRESETn = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [3:0] cmd_addr = 4'h0;
    logic [7:0] cmd_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       rsp_timeout;
    logic       busy;
    logic [3:0] PADDR;
    logic       PSELx;
    logic       PENABLE;
    logic       PWRITE;
    logic [7:0] PWDATA;
    logic       PREADY;
    logic [7:0] PRDATA;
    logic       PSLVERR;

    apb_master_bridge #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .TIMEOUT_CYCLES(4)) dut (
        .PCLK(clk), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout), .busy(busy),
        .PADDR(PADDR), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stub slave: PREADY after slv_wait low ACCESS cycles, never if stuck.
    logic [7:0] mem [16];
    int         slv_wait  = 0;
    logic       slv_err   = 1'b0;
    logic       slv_stuck = 1'b0;
    int         wcnt = 0;

    assign PREADY  = PSELx && PENABLE && !slv_stuck && (wcnt == slv_wait);
    assign PRDATA  = mem[PADDR];
    assign PSLVERR = slv_err && PREADY;

    always @(posedge clk) begin
        if (PSELx && PENABLE && !PREADY) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (PSELx && PENABLE && PREADY && PWRITE) mem[PADDR] <= PWDATA;
    end

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        logic       to;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    logic [3:0] cur_addr = 4'h0;
    logic [7:0] cur_wdata = 8'h00;
    logic       prev_valid = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares each response pulse with the head of the scoreboard
    // and checks the request stays stable during ACCESS.
    always @(negedge clk) begin
        if (PRESETn) begin
            if (PSELx && PENABLE) begin
                check("paddr_stable", PADDR, cur_addr);
                check("pwdata_stable", PWDATA, cur_wdata);
            end
            if (rsp_valid) begin
                check("rsp_pulse_width", prev_valid, 0);
                check("psel_low_at_rsp", PSELx, 0);
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", rsp_err, e.err);
                    check("rsp_timeout", rsp_timeout, e.to);
                    check("rsp_cycle", cyc, e.cyc);
                end
            end
        end
        prev_valid = rsp_valid;
    end

    task automatic issue(input logic wr, input logic [3:0] a, input logic [7:0] d,
                         input logic [7:0] e_rdata, input logic e_err, input logic e_to,
                         input int lat);
        int   n;
        exp_t e;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("cmd_accept_timeout", 0, 1);
        cur_addr  = a;
        cur_wdata = wr ? d : 8'h00;
        e.rdata = e_rdata;
        e.err   = e_err;
        e.to    = e_to;
        e.cyc   = cyc + 1 + lat;
        sb.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || busy) check("drain_timeout", 0, 1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[REG_UART_STAT] = 8'h21;

        repeat (3) @(negedge clk);
        check("rst_psel", PSELx, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_paddr", PADDR, 0);
        check("rst_pwrite", PWRITE, 0);
        check("rst_pwdata", PWDATA, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        PRESETn = 1'b1;

        // Zero-wait write, then confirm the slave captured it.
        issue(1'b1, REG_UART_CTRL, 8'h81, 8'h00, 1'b0, 1'b0, 2);
        drain();
        check("slave_ctrl", mem[REG_UART_CTRL], 8'h81);

        // Read with 3 wait states: PREADY on the last cycle before timeout wins.
        slv_wait = 3;
        issue(1'b0, REG_UART_STAT, 8'hAA, 8'h21, 1'b0, 1'b0, 5);
        drain();
        check("rdata_hold", rsp_rdata, 8'h21);

        // Slave error on a read and on a write.
        slv_wait = 0;
        slv_err  = 1'b1;
        issue(1'b0, REG_UART_STAT, 8'h00, 8'h21, 1'b1, 1'b0, 2);
        issue(1'b1, REG_UART_INT, 8'h03, 8'h00, 1'b1, 1'b0, 2);
        drain();
        slv_err = 1'b0;

        // PREADY stuck low: abort after 4 ACCESS cycles.
        slv_stuck = 1'b1;
        issue(1'b0, REG_UART_DATA, 8'h00, 8'h00, 1'b1, 1'b1, 5);
        drain();
        slv_stuck = 1'b0;

        // Recovery plus back-to-back traffic with one wait state.
        slv_wait = 1;
        issue(1'b1, REG_UART_DATA, 8'h55, 8'h00, 1'b0, 1'b0, 3);
        issue(1'b0, REG_UART_DATA, 8'h00, 8'h55, 1'b0, 1'b0, 3);
        issue(1'b0, REG_UART_CTRL, 8'h00, 8'h81, 1'b0, 1'b0, 3);
        drain();

        // Reset during ACCESS: bus idles on that edge, no response.
        slv_stuck = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = REG_UART_INT;
        cur_addr  = REG_UART_INT;
        cur_wdata = 8'h00;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("mid_access_penable", PENABLE, 1);
        PRESETn = 1'b0;
        @(negedge clk);
        check("mrst_psel", PSELx, 0);
        check("mrst_penable", PENABLE, 0);
        check("mrst_busy", busy, 0);
        check("mrst_rsp_valid", rsp_valid, 0);
        check("mrst_rsp_rdata", rsp_rdata, 0);
        PRESETn   = 1'b1;
        slv_stuck = 1'b0;
        slv_wait  = 0;

        issue(1'b0, REG_UART_CTRL, 8'h00, 8'h81, 1'b0, 1'b0, 2);
        drain();
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
